// File: rtl/fire_pkg.sv
// Shared types and helpers for the fire layer output path.
package fire_pkg;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned DSP_NO    = 256;
  localparam int unsigned WOUT      = 16;
  localparam int unsigned BASE_ADDR = 0;

  typedef logic [WIDTH-1:0] act_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  // Pixel-major activation RAM address. The base and vector length default to
  // the package values; callers with overridden parameters pass their own.
  function automatic int unsigned ofm_addr(input int unsigned pix,
                                           input int unsigned ch,
                                           input int unsigned base   = BASE_ADDR,
                                           input int unsigned dsp_no = DSP_NO);
    return base + pix * dsp_no + ch;
  endfunction

endpackage

// File: rtl/fire_ofm_ram_writer_if.sv
// Layer-to-writer bundle: sample strobe plus OFM vector in, RAM write port and
// status out.
//
// Handshake: there is no back-pressure. `sample` is a one-cycle valid strobe
// and `ofm` is only meaningful in that cycle; the writer either captures it
// (IDLE) or drops it and flags `overrun` (DRAIN). `ram_we` is a one-cycle
// write strobe with `ram_addr`/`ram_wdata` valid in the same cycle; the RAM is
// assumed always ready. `start` is a one-cycle command with top priority.
interface fire_ofm_ram_writer_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int AW     = 12
);

  logic                         start;
  logic                         sample;
  logic [0:DSP_NO-1][WIDTH-1:0] ofm;
  logic                         ram_we;
  logic [AW-1:0]                ram_addr;
  logic [WIDTH-1:0]             ram_wdata;
  logic                         ram_feedback;
  logic                         busy;
  logic                         done;
  logic                         overrun;

  // Layer / controller side.
  modport master (
    output start, sample, ofm,
    input  ram_we, ram_addr, ram_wdata, ram_feedback, busy, done, overrun
  );

  // Writer side.
  modport slave (
    input  start, sample, ofm,
    output ram_we, ram_addr, ram_wdata, ram_feedback, busy, done, overrun
  );

endinterface

// File: rtl/fire_ofm_ram_writer_ofm_vec_buffer.sv
// Capture register for one OFM vector: parallel load, indexed read.
// Contents are not reset; they are only read after a load.
module ofm_vec_buffer
  import fire_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int IW     = 8
) (
  input  logic                         clk,
  input  logic                         i_load,
  input  logic [0:DSP_NO-1][WIDTH-1:0] i_vec,
  input  logic [IW-1:0]                i_idx,
  output logic [WIDTH-1:0]             o_data
);

  logic [0:DSP_NO-1][WIDTH-1:0] r_buf;

  // Load the whole vector in the cycle the layer presents it.
  always_ff @(posedge clk) begin
    if (i_load) r_buf <= i_vec;
  end

  assign o_data = r_buf[i_idx];

endmodule

// File: rtl/fire_ofm_ram_writer.sv
// Consumer end of a fire expand layer: captures each sampled OFM vector and
// serialises it into the activation RAM one word per cycle, pixel-major.
// Pulses ram_feedback once the last pixel of the layer has been written.
module fire_ofm_ram_writer
  import fire_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DSP_NO    = 256,
  parameter int WOUT      = 16,
  parameter int BASE_ADDR = 0,
  parameter int AW        = $clog2(BASE_ADDR + WOUT**2 * DSP_NO)
) (
  input  logic                  clk,
  input  logic                  rst,
  fire_ofm_ram_writer_if.slave  bus
);

  localparam int NPIX = WOUT * WOUT;
  localparam int PW   = $clog2(NPIX + 1);
  localparam int CW   = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  wr_state_t        r_state;
  logic [PW-1:0]    r_pix_cnt;
  logic [CW-1:0]    r_ch_cnt;
  logic             r_ram_we;
  logic [AW-1:0]    r_ram_addr;
  logic [WIDTH-1:0] r_ram_wdata;
  logic             r_feedback;
  logic             r_done;
  logic             r_overrun;

  logic             w_load;
  logic             w_last_ch;
  logic [CW-1:0]    w_ch_nxt;
  logic [PW-1:0]    w_pix_nxt;
  logic [WIDTH-1:0] w_buf_data;

  // A vector is only captured from IDLE; start wins over a coincident sample.
  assign w_load    = (r_state == IDLE) && bus.sample && !bus.start;
  assign w_last_ch = (r_ch_cnt == CW'(DSP_NO - 1));
  assign w_ch_nxt  = r_ch_cnt + CW'(1);
  assign w_pix_nxt = r_pix_cnt + PW'(1);

  // The buffer is read one channel ahead so the registered write data for
  // the next cycle is ready at the edge.
  ofm_vec_buffer #(
    .WIDTH  (WIDTH),
    .DSP_NO (DSP_NO),
    .IW     (CW)
  ) u_buf (
    .clk    (clk),
    .i_load (w_load),
    .i_vec  (bus.ofm),
    .i_idx  (w_ch_nxt),
    .o_data (w_buf_data)
  );

  // Writer FSM with counters and registered RAM port. r_ch_cnt names the
  // channel currently presented on the RAM port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pix_cnt   <= '0;
      r_ch_cnt    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_feedback  <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (bus.start) begin
      r_state    <= IDLE;
      r_pix_cnt  <= '0;
      r_ch_cnt   <= '0;
      r_ram_we   <= 1'b0;
      r_feedback <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_feedback <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.sample) begin
            // Channel 0 comes straight from the input; the buffer is still
            // loading at this edge.
            r_state     <= DRAIN;
            r_ch_cnt    <= '0;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= AW'(ofm_addr(32'(r_pix_cnt), 32'd0,
                                        BASE_ADDR, DSP_NO));
            r_ram_wdata <= bus.ofm[0];
          end
        end
        DRAIN: begin
          // Any sample here, including on the exit edge, is lost.
          if (bus.sample) r_overrun <= 1'b1;
          if (w_last_ch) begin
            r_ram_we  <= 1'b0;
            r_pix_cnt <= w_pix_nxt;
            if (w_pix_nxt == PW'(NPIX)) begin
              r_state    <= DONE;
              r_feedback <= 1'b1;
              r_done     <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_ch_cnt    <= w_ch_nxt;
            r_ram_addr  <= AW'(ofm_addr(32'(r_pix_cnt), 32'(w_ch_nxt),
                                        BASE_ADDR, DSP_NO));
            r_ram_wdata <= w_buf_data;
          end
        end
        DONE: begin
          r_ram_we <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_we       = r_ram_we;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_wdata    = r_ram_wdata;
  assign bus.ram_feedback = r_feedback;
  assign bus.busy         = (r_state == DRAIN);
  assign bus.done         = r_done;
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_fire_ofm_ram_writer.sv
// Randomised bench for fire_ofm_ram_writer against a transaction-level model:
// each accepted sample expands into DSP_NO timed RAM writes.
module tb_fire_ofm_ram_writer;

  localparam int WIDTH     = 16;
  localparam int DSP_NO    = 4;
  localparam int WOUT      = 2;
  localparam int BASE_ADDR = 16;
  localparam int AW        = 5;
  localparam int NPIX      = WOUT * WOUT;
  localparam int EW        = 32 + AW + WIDTH;
  localparam int INF       = 1 << 30;

  typedef logic [0:DSP_NO-1][WIDTH-1:0] vec_t;

  logic clk;
  logic rst;

  fire_ofm_ram_writer_if #(.WIDTH(WIDTH), .DSP_NO(DSP_NO), .AW(AW)) bus ();

  fire_ofm_ram_writer #(
    .WIDTH     (WIDTH),
    .DSP_NO    (DSP_NO),
    .WOUT      (WOUT),
    .BASE_ADDR (BASE_ADDR),
    .AW        (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // Entry: {cycle the write is visible, address, data}
  logic [EW-1:0] exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;

  int  last_e   = -100;
  int  m_pix    = 0;
  bit  m_done   = 1'b0;
  int  fb_cyc   = INF;
  int  done_cyc = INF;
  int  ov_cyc   = INF;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_sample(input vec_t vec);
    int e;
    @(negedge clk);
    #1;
    e = cyc + 1;
    if (e <= last_e + DSP_NO) begin
      if (ov_cyc > e) ov_cyc = e;
    end else if (!m_done) begin
      for (int k = 0; k < DSP_NO; k++)
        exp_q.push_back({32'(e + k), AW'(BASE_ADDR + m_pix * DSP_NO + k), vec[k]});
      last_e = e;
      m_pix++;
      if (m_pix == NPIX) begin
        m_done   = 1'b1;
        fb_cyc   = e + DSP_NO;
        done_cyc = e + DSP_NO;
      end
    end
    bus.sample = 1'b1;
    bus.ofm    = vec;
    @(posedge clk);
    #1;
    bus.sample = 1'b0;
  endtask

  task automatic drive_start();
    int e;
    logic [EW-1:0] keep_q[$];
    @(negedge clk);
    #1;
    e = cyc + 1;
    keep_q = {};
    foreach (exp_q[i])
      if (int'(exp_q[i][EW-1 -: 32]) < e) keep_q.push_back(exp_q[i]);
    exp_q = keep_q;
    if (fb_cyc >= e) fb_cyc = INF;
    done_cyc = INF;
    ov_cyc   = INF;
    m_done   = 1'b0;
    m_pix    = 0;
    last_e   = -100;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int k = 0; k < DSP_NO; k++) v[k] = WIDTH'($urandom);
    return v;
  endfunction

  // ---------------- monitor ----------------
  logic          m_exp_we;
  logic [EW-1:0] m_ent;
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
        m_ent = exp_q.pop_front();
        chk("missed_write", 64'(bus.ram_we), 64'(1));
      end
      m_exp_we = (exp_q.size() > 0) && (int'(exp_q[0][EW-1 -: 32]) == cyc);
      chk("ram_we", 64'(bus.ram_we), 64'(m_exp_we));
      chk("busy", 64'(bus.busy), 64'(m_exp_we));
      if (m_exp_we) begin
        m_ent = exp_q.pop_front();
        chk("ram_addr", 64'(bus.ram_addr), 64'(m_ent[WIDTH +: AW]));
        chk("ram_wdata", 64'(bus.ram_wdata), 64'(m_ent[WIDTH-1:0]));
      end
      chk("ram_feedback", 64'(bus.ram_feedback), 64'(cyc == fb_cyc));
      chk("done", 64'(bus.done), 64'(cyc >= done_cyc));
      chk("overrun", 64'(bus.overrun), 64'(cyc >= ov_cyc));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.sample = 1'b0;
    bus.ofm    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", 64'(bus.ram_we), 64'(0));
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
    chk("rst_ram_wdata", 64'(bus.ram_wdata), 64'(0));
    chk("rst_feedback", 64'(bus.ram_feedback), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_overrun", 64'(bus.overrun), 64'(0));
    rst    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Single pixel with known data, then the rest of the layer.
    v = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
    drive_sample(v);
    idle(9);
    for (int p = 1; p < NPIX; p++) begin
      drive_sample(rand_vec());
      idle(9);
    end

    // Sample in DONE is ignored.
    drive_sample(rand_vec());
    idle(6);

    // Re-arm, then overrun two cycles after the first sample.
    drive_start();
    drive_sample(rand_vec());
    idle(1);
    drive_sample(rand_vec());
    idle(8);

    // Random spacing with occasional restarts.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) drive_start();
      drive_sample(rand_vec());
      idle($urandom_range(0, 10));
    end
    idle(10);

    // Abort a drain with start in its second write cycle.
    drive_start();
    drive_sample(rand_vec());
    idle(1);
    drive_start();
    idle(3);
    drive_sample(rand_vec());
    idle(8);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    // Asynchronous reset between clock edges mid-drain.
    drive_sample(rand_vec());
    @(negedge clk);
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    chk("async_ram_we", 64'(bus.ram_we), 64'(0));
    chk("async_busy", 64'(bus.busy), 64'(0));
    chk("async_done", 64'(bus.done), 64'(0));
    chk("async_feedback", 64'(bus.ram_feedback), 64'(0));
    exp_q = {};
    idle(2);
    chk("reset_hold_we", 64'(bus.ram_we), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fire_ofm_ram_writer.md
Name: fire_ofm_ram_writer

Overview:
- Consumer end of a fire expand layer's output interface.
- On each layer `sample` pulse it captures the full parallel output-feature-map vector `ofm[0:DSP_NO-1]`, then serialises it into the activation RAM, one word per cycle, in pixel-major order.
- After WOUT**2 pixels have been written it pulses `ram_feedback`; the layer uses this to drop its finish flag and the controller uses it to hand the RAM to the next layer.

Parameters:
- WIDTH, 16, activation word width.
- DSP_NO, 256, number of output channels per sample (vector length).
- WOUT, 16, output spatial dimension; pixels per layer = WOUT**2.
- BASE_ADDR, 0, RAM word address of pixel 0 / channel 0.
- AW, $clog2(BASE_ADDR+WOUT**2*DSP_NO), RAM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; re-arms the writer for a new layer.
- sample  in  1  one-cycle pulse; `ofm` is valid in this cycle.
- ofm  in  WIDTH x [0:DSP_NO-1]  parallel layer output vector.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM write address.
- ram_wdata  out  WIDTH  RAM write data.
- ram_feedback  out  1  one-cycle pulse when the last word of the layer is written.
- busy  out  1  high while draining a captured vector.
- done  out  1  level; layer fully written, held until `start`.
- overrun  out  1  sticky; `sample` arrived while `busy`; cleared by `start`.

Behaviour:
- Reset values: all outputs 0, state IDLE, pix_cnt=0, ch_cnt=0. Capture buffer contents are don't-care and are not reset.
- FSM states: IDLE, DRAIN, DONE.
- IDLE, `sample`=1: at that edge copy `ofm` into buffer `buf[0:DSP_NO-1]`, set ch_cnt=0, go to DRAIN.
- DRAIN, each cycle:
  - ram_we=1, ram_addr=BASE_ADDR+pix_cnt*DSP_NO+ch_cnt, ram_wdata=buf[ch_cnt]. Outputs are registered.
  - The first write is the cycle after `sample`; the drain lasts exactly DSP_NO cycles.
- End of DRAIN (ch_cnt==DSP_NO-1):
  - pix_cnt increments.
  - If the new pix_cnt==WOUT**2: go to DONE, pulse ram_feedback for 1 cycle (the cycle after the last write), set done=1.
  - Otherwise return to IDLE.
- `sample` while in DRAIN:
  - The vector is dropped and the buffer is not modified.
  - overrun<=1.
  - The in-progress drain completes unaffected.
- `sample` on the same edge DRAIN exits to IDLE: treated as busy, so it is dropped and overrun is set. The layer's sample spacing (KERNEL_DIM**2*CHIN+1 cycles) must be at least DSP_NO+1.
- DONE:
  - `sample` is ignored and does not set overrun.
  - ram_we=0.
- `start`, in any state:
  - Next state IDLE; pix_cnt=0, ch_cnt=0, done=0, overrun=0, ram_we=0.
  - An aborted drain leaves a partially written pixel in RAM.
  - `start` has priority over a simultaneous `sample`.
- Reset asserted mid-drain: outputs go to 0 immediately (async); no further writes.
- busy = (state==DRAIN).
- Address arithmetic is unsigned, computed at AW bits with no wrap. The last address is BASE_ADDR+WOUT**2*DSP_NO-1.

Decomposition:
- Shared package `fire_pkg`:
  - typedef `act_t` = logic [WIDTH-1:0].
  - enum `wr_state_t` {IDLE, DRAIN, DONE}.
  - function `ofm_addr(pix, ch)` returning BASE_ADDR+pix*DSP_NO+ch.
- One natural sub-module, `ofm_vec_buffer`: a DSP_NO-entry capture register with a parallel load and an indexed read mux. The FSM, counters and address generation stay in the top module.

Test Plan (WIDTH=16, DSP_NO=4, WOUT=2, BASE_ADDR=16 unless stated):
- Single pixel: `sample` with ofm={0x11,0x22,0x33,0x44} → writes at cycles +1..+4 to addresses 16,17,18,19 with data 0x11,0x22,0x33,0x44; busy high for 4 cycles; ram_we=0 at +5.
- Full layer: 4 samples spaced 10 cycles apart → 16 writes at addresses 16..31; ram_feedback high for exactly 1 cycle, one cycle after the write to address 31; done=1 thereafter; overrun=0.
- Overrun: second `sample` 2 cycles after the first → first vector fully written; second vector never written; overrun=1 and sticky; pix_cnt advances by 1 only.
- Post-done: 5th `sample` in DONE → no write, overrun stays 0. Then `start` → done=0, and the next `sample` writes to address 16 again.
- Start abort: `start` during the 2nd drain cycle → ram_we=0 on the next cycle; the following `sample` writes to addresses 16..19.
- Async reset: assert rst mid-drain without a clock edge → ram_we, busy, done and ram_feedback all read 0 immediately.
